// File: rtl/multiplication_pkg.sv
// Shared constants and types for the shift-add multiply-accumulate unit.
package multiplication_pkg;

   localparam int unsigned DEFAULT_WIDTH = 64;

   // Controller state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit-counter width for a given operand width (at least one bit)
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/multiplication_if.sv
// Start/ready request bus carrying the three operands and the 2W-bit result.
interface multiplication_if #(
   parameter int unsigned WIDTH = multiplication_pkg::DEFAULT_WIDTH
);
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic [WIDTH-1:0] addend;
   logic             start;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;
   logic             ready;

   // Requester side
   modport master (
      output multiplicand, multiplier, addend, start,
      input  product_hi, product_lo, ready
   );

   // Arithmetic unit side
   modport slave (
      input  multiplicand, multiplier, addend, start,
      output product_hi, product_lo, ready
   );
endinterface

// File: rtl/multiplication_controller.sv
// Sequencer: accepts a request, runs W shift-add steps, then one capture step.
module multiplication_controller
   import multiplication_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic ready,
   output logic load_c,
   output logic shift_c,
   output logic capture_c
);

   localparam int unsigned    CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             last_q,  last_d;
   logic             ready_q, ready_d;

   // State, bit counter, shift-finished flag and ready flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         last_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         last_q  <= last_d;
         ready_q <= ready_d;
      end
   end

   // Next-state and step enables; last_q inserts the capture cycle after the final shift
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      last_d    = last_q;
      load_c    = 1'b0;
      shift_c   = 1'b0;
      capture_c = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = BUSY;
               load_c  = 1'b1;
               count_d = '0;
               last_d  = 1'b0;
            end
         end
         BUSY: begin
            if (!last_q) begin
               shift_c = 1'b1;
               if (count_q == LAST_CNT) begin
                  count_d = '0;
                  last_d  = 1'b1;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end else begin
               capture_c = 1'b1;
               last_d    = 1'b0;
               state_d   = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d != BUSY);
   end

   assign ready = ready_q;

endmodule

// File: rtl/multiplication_datapath.sv
// Operand registers, conditional adder, right shifter and result registers.
module multiplication_datapath
   import multiplication_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   input  logic [WIDTH-1:0] addend,
   input  logic             load_c,
   input  logic             shift_c,
   input  logic             capture_c,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo
);

   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH:0]   hi_q,     hi_d;
   logic [WIDTH-1:0] lo_q,     lo_d;
   logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
   logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

   logic [WIDTH:0]   add_term;
   logic [WIDTH:0]   sum;

   // Working and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         prod_hi_q <= '0;
         prod_lo_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         prod_hi_q <= prod_hi_d;
         prod_lo_q <= prod_lo_d;
      end
   end

   // Partial-product add; hi is below 2^W before the add, so W+1 bits never overflow
   always_comb begin
      add_term = lo_q[0] ? {1'b0, mcand_q} : '0;
      sum      = hi_q + add_term;
   end

   // Load operands (addend pre-seeds hi), shift {sum,lo} right, capture the final result
   always_comb begin
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      prod_hi_d = prod_hi_q;
      prod_lo_d = prod_lo_q;

      if (load_c) begin
         mcand_d = multiplicand;
         hi_d    = {1'b0, addend};
         lo_d    = multiplier;
      end else if (shift_c) begin
         hi_d    = {1'b0, sum[WIDTH:1]};
         lo_d    = {sum[0], lo_q[WIDTH-1:1]};
      end

      if (capture_c) begin
         prod_hi_d = hi_q[WIDTH-1:0];
         prod_lo_d = lo_q;
      end
   end

   assign product_hi = prod_hi_q;
   assign product_lo = prod_lo_q;

endmodule

// File: rtl/multiplication_top.sv
// Sequential multiply-accumulate unit: product = multiplicand * multiplier + addend.
module multiplication_top
   import multiplication_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   multiplication_if.slave  bus
);

   logic load_c;
   logic shift_c;
   logic capture_c;

   multiplication_controller #(
      .WIDTH (WIDTH)
   ) u_controller (
      .clk       (clk),
      .reset     (reset),
      .start     (bus.start),
      .ready     (bus.ready),
      .load_c    (load_c),
      .shift_c   (shift_c),
      .capture_c (capture_c)
   );

   multiplication_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk          (clk),
      .reset        (reset),
      .multiplicand (bus.multiplicand),
      .multiplier   (bus.multiplier),
      .addend       (bus.addend),
      .load_c       (load_c),
      .shift_c      (shift_c),
      .capture_c    (capture_c),
      .product_hi   (bus.product_hi),
      .product_lo   (bus.product_lo)
   );

endmodule

// File: tb/tb_multiplication_top.sv
// Directed bench for the shift-add multiply-accumulate unit.
module tb_multiplication_top;

   localparam int unsigned W       = 64;
   localparam int          LAT     = 65;   // ready-low cycles per operation (W+1)
   localparam int          MAX_CYC = 200;

   logic clk = 1'b0;
   logic reset;

   multiplication_if #(.WIDTH(W)) bus ();

   multiplication_top #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] ref_mac(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c);
      return 128'(a) * 128'(b) + 128'(c);
   endfunction

   function automatic logic [127:0] product();
      return {bus.product_hi, bus.product_lo};
   endfunction

   // Count ready-low negedges until ready returns (bounded)
   task automatic wait_ready(output int lows);
      lows = 0;
      for (int k = 0; k < MAX_CYC; k++) begin
         if (bus.ready) break;
         lows++;
         @(negedge clk);
      end
   endtask

   // One operation with start pulsed for a single cycle
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [127:0] exp);
      int lows;
      @(negedge clk);
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.addend       = c;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_ready(lows);
      check_eq({tag, "_result"}, product(), exp);
      check_eq({tag, "_latency"}, 128'(lows), 128'(LAT));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0]  a, b, c;
      logic [127:0] exp;
      int           lows;

      reset            = 1'b1;
      bus.start        = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      bus.addend       = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_ready", 128'(bus.ready), 128'(1));
      check_eq("reset_product", product(), 128'(0));
      reset = 1'b0;
      @(negedge clk);
      check_eq("idle_ready", 128'(bus.ready), 128'(1));

      // Basic directed vectors
      run_op("zero_mcand", 64'd0, 64'd27, 64'd17, 128'd17);
      run_op("small", 64'd3, 64'd5, 64'd2, 128'd17);
      run_op("all_zero", 64'd0, 64'd0, 64'd0, 128'd0);
      run_op("all_ones", '1, '1, '1, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
      run_op("mixed", 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd5,
             {64'd1, 64'd5});

      // Back-to-back operations with start held high
      a = 64'h0123_4567_89AB_CDEF;
      b = 64'd3;
      c = 64'd7;
      @(negedge clk);
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.addend       = c;
      bus.start        = 1'b1;
      for (int i = 0; i < 100; i++) begin
         exp = ref_mac(a, b, c);
         @(negedge clk);
         check_eq("stream_ready_drop", 128'(bus.ready), 128'(0));
         wait_ready(lows);
         check_eq("stream_latency", 128'(lows), 128'(LAT));
         check_eq("stream_result", product(), exp);
         a = a * 64'd6364136223846793005 + 64'd1442695040888963407;
         b = b * 64'd5;
         c = c * 64'd3;
         bus.multiplicand = a;
         bus.multiplier   = b;
         bus.addend       = c;
         if (i == 99) bus.start = 1'b0;
      end

      // DONE with start low: result held
      repeat (5) @(negedge clk);
      check_eq("done_hold_ready", 128'(bus.ready), 128'(1));
      check_eq("done_hold_result", product(), exp);

      // Inputs and start scrambled during BUSY
      bus.multiplicand = 64'd7;
      bus.multiplier   = 64'd9;
      bus.addend       = 64'd1;
      bus.start        = 1'b1;
      @(negedge clk);
      lows = 0;
      for (int k = 0; k < MAX_CYC; k++) begin
         if (bus.ready) break;
         lows++;
         bus.multiplicand = {$urandom, $urandom};
         bus.multiplier   = {$urandom, $urandom};
         bus.addend       = {$urandom, $urandom};
         bus.start        = (k < 10);
         @(negedge clk);
      end
      bus.start = 1'b0;
      check_eq("busy_ignore_result", product(), 128'd64);
      check_eq("busy_ignore_latency", 128'(lows), 128'(LAT));

      // Reset during BUSY discards the operation
      bus.multiplicand = 64'd123;
      bus.multiplier   = 64'd456;
      bus.addend       = 64'd789;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      check_eq("mid_busy_ready", 128'(bus.ready), 128'(0));
      #2 reset = 1'b1;
      #1;
      check_eq("async_reset_ready", 128'(bus.ready), 128'(1));
      check_eq("async_reset_product", product(), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("post_reset_idle", 128'(bus.ready), 128'(1));
      run_op("after_reset", 64'd2, 64'd3, 64'd0, 128'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multiplication_top.md
# multiplication_top

Sequential shift-add multiply-accumulate unit computing product = multiplicand × multiplier + addend at full 2W-bit precision, one multiplier bit per clock. It is the inverse of the structural divider: feeding it a quotient, divisor and remainder reconstructs the dividend. It uses the same start/ready handshake as the divider, so both can share benches and sit side by side in the arithmetic datapath.

## Interface
- WIDTH, 64, operand width W; product is 2W bits
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- multiplicand  input  W  operand a (captured on accept)
- multiplier  input  W  operand b (captured on accept)
- addend  input  W  operand c (captured on accept)
- start  input  1  request; level-sensitive, sampled on rising edge
- product_hi  output  W  upper W bits of a×b+c
- product_lo  output  W  lower W bits of a×b+c
- ready  output  1  unit idle, product outputs valid

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: ready=1, products 0. start=1 at an edge → BUSY.
- DONE: ready=1, products hold last result. start=1 at an edge → BUSY (back-to-back allowed).
- Accept (start=1 while ready=1): capture a into mcand reg; hi ← c (W+1 bits, carry bit 0); lo ← b; count ← 0; ready drops at that edge.
- Each BUSY edge: sum = hi + (lo[0] ? a : 0) (W+1 bits, no overflow since hi ≤ 2^W−1 before add); {hi,lo} ← {sum,lo} >> 1; count ← count+1.
- After W BUSY edges (count wraps at W−1) → DONE; product_hi/lo ← final {hi,lo}.
- Result never overflows: max (2^W−1)² + (2^W−1) < 2^(2W).
- start ignored while BUSY; input changes during BUSY have no effect.
- start held continuously high: each result is visible for exactly one cycle with ready=1 before the next operation begins.
- Outputs driven only from registers; product registers update only on the BUSY→DONE transition.

## Timing
- Reset (any time, including mid-BUSY): immediate → IDLE, ready=1, product_hi=product_lo=0, count=0, internal regs 0; operation in flight discarded.
- Accepting edge E: ready=0 from E until edge E+W+1, where ready=1 and products valid. Latency fixed at W+1 edges, independent of operand values (no early termination).
- ready low for exactly W+1 cycles per operation; throughput one result per W+1 cycles with start held high.
- Deasserting start in DONE: unit stays in DONE indefinitely, outputs stable.

## Structure
- Package multiplication_pkg: WIDTH default, state encoding constants (IDLE, BUSY, DONE), counter width $clog2(WIDTH).
- Sub-module multiplication_controller: FSM, bit counter, ready, load/shift/capture enables.
- Sub-module multiplication_datapath: mcand, hi (W+1), lo registers, adder, shifter, product output registers.
- multiplication_top: structural instantiation of the two only, no logic.

## Test plan
- Reset then a=0, b=27, c=17, start=1 → after W+1 edges ready=1, product_hi=0, product_lo=17; ready low exactly W+1 cycles.
- a=3, b=5, c=2 → product_lo=17, product_hi=0; a=0, b=0, c=0 → 0.
- a=b=c=2^64−1 → product_hi=0xFFFFFFFFFFFFFFFF, product_lo=0x0000000000000000 (no overflow).
- start held high, 100 ops with b×5, c×3 per op (truncated to W) → each result equals a×b+c mod 2^128 against a reference model; ready high exactly one cycle between ops.
- Accept a=7, b=9, c=1; change all inputs to random values during BUSY → result 64.
- Assert reset at BUSY cycle 20 of an op → ready=1, products 0 immediately; next start a=2, b=3, c=0 → product_lo=6.
